// File: rtl/lb_regbank.sv
// lb_regbank -- parametrised local-bus register bank.
//
// Every accepted command is echoed on the response channel exactly RDLAT
// cycles later. The bank holds three register classes, laid out from BASE:
//   [0, NRW)                    RW config registers with one-cycle write strobes
//   [NRW, NRW+NRO)              RO status registers, sampled from status_in
//   [NRW+NRO, NRW+NRO+NSTICKY)  sticky event registers, cleared on read
// Any other offset is unmapped and reads back UNMAPPED.
//
// Ports:
//   clk, rst    bus clock, asynchronous active-high reset
//   wvalid      command valid; one command per cycle, no backpressure
//   wctrl       command (WRITECMD / READCMD / anything else is echoed only)
//   waddr       word address
//   wdata       write data
//   rready      response valid, one cycle per accepted command
//   rctrl       echoed command
//   raddr       echoed address
//   rdata       read data for reads, echoed wdata otherwise
//   cfg_regs    flat RW register contents, reg i at [i*LBDWIDTH +: LBDWIDTH]
//   cfg_stb     per-register one-cycle write pulse
//   status_in   flat RO register values
//   sticky_set  flat per-bit set pulses for the sticky registers
module lb_regbank #(
  parameter int                              LBCWIDTH = 8,
  parameter int                              LBAWIDTH = 24,
  parameter int                              LBDWIDTH = 32,
  parameter logic [LBCWIDTH-1:0]             WRITECMD = 1,
  parameter logic [LBCWIDTH-1:0]             READCMD  = 0,
  parameter logic [LBAWIDTH-1:0]             BASE     = '0,
  parameter int                              NRW      = 8,
  parameter int                              NRO      = 4,
  parameter int                              NSTICKY  = 2,
  parameter int                              RDLAT    = 3,
  parameter logic [NRW*LBDWIDTH-1:0]         RW_RESET = '0,
  parameter logic [31:0]                     UNMAPPED = 32'hdeadbeef
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         wvalid,
  input  logic [LBCWIDTH-1:0]                          wctrl,
  input  logic [LBAWIDTH-1:0]                          waddr,
  input  logic [LBDWIDTH-1:0]                          wdata,
  output logic                                         rready,
  output logic [LBCWIDTH-1:0]                          rctrl,
  output logic [LBAWIDTH-1:0]                          raddr,
  output logic [LBDWIDTH-1:0]                          rdata,
  output logic [NRW*LBDWIDTH-1:0]                      cfg_regs,
  output logic [NRW-1:0]                               cfg_stb,
  input  logic [(NRO>0 ? NRO : 1)*LBDWIDTH-1:0]        status_in,
  input  logic [(NSTICKY>0 ? NSTICKY : 1)*LBDWIDTH-1:0] sticky_set
);

  // Storage arrays need at least one element even when a class is empty.
  localparam int NST_S = (NSTICKY > 0) ? NSTICKY : 1;

  // ---------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------
  logic [LBAWIDTH-1:0] w_off;
  logic                w_is_wr;
  logic                w_is_rd;
  logic [NRW-1:0]      w_rw_hit;
  logic [NST_S-1:0]    w_st_hit;
  logic [LBDWIDTH-1:0] w_rd_data;
  logic [LBDWIDTH-1:0] w_resp_data;

  logic [LBDWIDTH-1:0] r_cfg    [NRW];
  logic [LBDWIDTH-1:0] r_sticky [NST_S];
  logic [NRW-1:0]      r_stb;

  // Offset wraps modulo 2^LBAWIDTH, so addresses below BASE land far out of
  // range and decode as unmapped.
  assign w_off   = waddr - BASE;
  assign w_is_wr = (wctrl == WRITECMD);
  assign w_is_rd = (wctrl == READCMD);

  always_comb begin
    w_rw_hit  = '0;
    w_st_hit  = '0;
    w_rd_data = LBDWIDTH'(UNMAPPED);
    for (int unsigned i = 0; i < NRW; i++) begin
      if (w_off == LBAWIDTH'(i)) begin
        w_rw_hit[i] = 1'b1;
        w_rd_data   = r_cfg[i];
      end
    end
    for (int unsigned i = 0; i < NRO; i++) begin
      if (w_off == LBAWIDTH'(NRW + i)) begin
        w_rd_data = status_in[i*LBDWIDTH +: LBDWIDTH];
      end
    end
    for (int unsigned i = 0; i < NSTICKY; i++) begin
      if (w_off == LBAWIDTH'(NRW + NRO + i)) begin
        w_st_hit[i] = 1'b1;
        w_rd_data   = r_sticky[i];
      end
    end
  end

  // Reads return pre-update state; everything else echoes wdata.
  assign w_resp_data = w_is_rd ? w_rd_data : wdata;

  // ---------------------------------------------------------------------
  // Register state
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NRW; i++) begin
        r_cfg[i] <= RW_RESET[i*LBDWIDTH +: LBDWIDTH];
      end
      for (int unsigned i = 0; i < NST_S; i++) begin
        r_sticky[i] <= '0;
      end
      r_stb <= '0;
    end else begin
      r_stb <= '0;
      for (int unsigned i = 0; i < NRW; i++) begin
        if (wvalid && w_is_wr && w_rw_hit[i]) begin
          r_cfg[i] <= wdata;
          r_stb[i] <= 1'b1;
        end
      end
      // Clear-on-read is applied first so a coincident set pulse survives.
      for (int unsigned i = 0; i < NSTICKY; i++) begin
        r_sticky[i] <= ((wvalid && w_is_rd && w_st_hit[i]) ? '0 : r_sticky[i])
                       | sticky_set[i*LBDWIDTH +: LBDWIDTH];
      end
    end
  end

  always_comb begin
    cfg_regs = '0;
    for (int unsigned i = 0; i < NRW; i++) begin
      cfg_regs[i*LBDWIDTH +: LBDWIDTH] = r_cfg[i];
    end
  end

  assign cfg_stb = r_stb;

  // ---------------------------------------------------------------------
  // Response pipeline
  // ---------------------------------------------------------------------
  logic                r_pv [RDLAT];
  logic [LBCWIDTH-1:0] r_pc [RDLAT];
  logic [LBAWIDTH-1:0] r_pa [RDLAT];
  logic [LBDWIDTH-1:0] r_pd [RDLAT];

  // Payload of a stage only loads when a valid entry moves into it, so the
  // last stage (the response outputs) holds its value while rready is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < RDLAT; k++) begin
        r_pv[k] <= 1'b0;
        r_pc[k] <= '0;
        r_pa[k] <= '0;
        r_pd[k] <= '0;
      end
    end else begin
      r_pv[0] <= wvalid;
      if (wvalid) begin
        r_pc[0] <= wctrl;
        r_pa[0] <= waddr;
        r_pd[0] <= w_resp_data;
      end
      for (int unsigned k = 1; k < RDLAT; k++) begin
        r_pv[k] <= r_pv[k-1];
        if (r_pv[k-1]) begin
          r_pc[k] <= r_pc[k-1];
          r_pa[k] <= r_pa[k-1];
          r_pd[k] <= r_pd[k-1];
        end
      end
    end
  end

  assign rready = r_pv[RDLAT-1];
  assign rctrl  = r_pc[RDLAT-1];
  assign raddr  = r_pa[RDLAT-1];
  assign rdata  = r_pd[RDLAT-1];

endmodule

// File: doc/lb_regbank.md
Name: lb_regbank

Overview:
- Parametrised local-bus register bank. Successor to the fixed register-map decode.
- Accepts write/read commands from the local bus master and echoes every command on the response channel after a configurable, aligned latency.
- Implements three register classes:
  - RW config registers, with per-register write strobes.
  - RO status registers.
  - Sticky clear-on-read event registers.
- One instance sits per subsystem; several instances share one bus via distinct BASE addresses.

Parameters:
- LBCWIDTH, 8, command field width
- LBAWIDTH, 24, address width
- LBDWIDTH, 32, data width
- WRITECMD, 1, wctrl value meaning write
- READCMD, 0, wctrl value meaning read
- BASE, 0, word address of first register
- NRW, 8, number of RW config registers (>=1)
- NRO, 4, number of RO status registers (>=0)
- NSTICKY, 2, number of sticky clear-on-read registers (>=0)
- RDLAT, 3, request-to-response latency in cycles (>=1)
- RW_RESET, all zeros, NRW*LBDWIDTH flat reset values of RW registers
- UNMAPPED, 32'hdeadbeef, read data for unmapped addresses (truncated/zero-extended to LBDWIDTH)

Ports:
- clk  input  1  local bus clock
- rst  input  1  asynchronous active-high reset
- wvalid  input  1  command valid, one command per cycle
- wctrl  input  LBCWIDTH  command
- waddr  input  LBAWIDTH  word address
- wdata  input  LBDWIDTH  write data
- rready  output  1  response valid
- rctrl  output  LBCWIDTH  echoed command
- raddr  output  LBAWIDTH  echoed address
- rdata  output  LBDWIDTH  read data, or echoed wdata
- cfg_regs  output  NRW*LBDWIDTH  RW register contents, reg i at [i*LBDWIDTH +: LBDWIDTH]
- cfg_stb  output  NRW  one-cycle pulse when reg i is written
- status_in  input  NRO*LBDWIDTH  RO register values, sampled at read
- sticky_set  input  NSTICKY*LBDWIDTH  per-bit set pulses for sticky registers

Behaviour:
- Reset (asynchronous, active-high, clk domain):
  - rready=0; rctrl, raddr, rdata=0.
  - cfg_regs=RW_RESET; cfg_stb=0; sticky registers=0.
  - Response pipeline flushed; commands in flight during reset are dropped, with no late rready.
- Decode, on offset off=waddr-BASE computed in LBAWIDTH bits (wraps modulo 2^LBAWIDTH):
  - off<NRW: RW reg off.
  - NRW<=off<NRW+NRO: RO reg off-NRW.
  - NRW+NRO<=off<NRW+NRO+NSTICKY: sticky reg.
  - Any other offset is unmapped.
- Accept: a command is accepted in cycle T iff wvalid=1 at the T rising edge. No backpressure; back-to-back every cycle is supported.
- Write (wctrl==WRITECMD) to RW reg i:
  - cfg_regs[i]=wdata from T+1.
  - cfg_stb[i]=1 during T+1 only.
  - Writes to RO, sticky or unmapped addresses have no effect and no strobe.
- Read (wctrl==READCMD):
  - Data is the register state at T, i.e. before any same-cycle effect; status_in is sampled at T.
  - Unmapped addresses return UNMAPPED.
  - A sticky read clears the register at T+1, except bits with sticky_set=1 at T, which end up set.
- Sticky regs: bit b becomes 1 at T+1 if sticky_set bit b=1 at T. When set and clear coincide, set wins.
- Response for every accepted command:
  - rready=1 in cycle T+RDLAT, for exactly one cycle per command.
  - rctrl=wctrl, raddr=waddr of that command.
  - rdata = read data for reads; wdata echoed for writes and for any other wctrl.
  - Response fields are all aligned in the same cycle.
  - rctrl, raddr, rdata hold their last value when rready=0.
- Pipeline: RDLAT-stage shift of {valid, ctrl, addr, data}. Commands stay ordered, and a response emerges every cycle for back-to-back commands.
- Other wctrl values: echoed, with no register side effects.

Test Plan:
- Reset, then write 0x12345678 to BASE+2 at cycle T:
  - cfg_regs[2]=0x12345678 at T+1; cfg_stb=8'b00000100 only at T+1.
  - rready at T+3 with rctrl=1, raddr=BASE+2, rdata=0x12345678.
- Back-to-back commands:
  - Write 0xA5 to BASE+0 at T, read BASE+0 at T+1.
  - Read response at T+4 returns 0xA5.
  - Read BASE+0 at T concurrent with the write instead: returns the prior value 0.
- Address decode:
  - status_in reg1=0xCAFE0001; read BASE+NRW+1 returns 0xCAFE0001.
  - Read BASE+NRW+NRO+NSTICKY returns 0xdeadbeef.
  - Write to BASE+NRW leaves all cfg_regs unchanged with no strobe.
- Sticky registers:
  - Pulse sticky_set reg0 bit 3, then read sticky reg0: returns 0x8. A second read returns 0x0.
  - sticky_set bit 5 in the same cycle as a read (state 0x8): read returns 0x8, and the next read returns 0x20.
- Reset with 2 reads in flight: no rready after rst asserts; cfg_regs return to RW_RESET immediately, without waiting for clk.
- Repeat the first scenario with RDLAT=1 and RDLAT=5: rready at T+1 and T+5 respectively. Repeat with a non-zero BASE and an address below BASE that wraps: the command is treated as unmapped.
